// File: rtl/dec_scan_n.sv
// Registered N-to-2^N one-hot decoder with an index register that can be loaded
// directly, auto-scanned through a prescaler, or swept once with busy/done handshake.
module dec_scan_n #(
   parameter int N          = 2,
   parameter int DIV        = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            e,
   input  logic [N-1:0]    i,
   input  logic [1:0]      mode,
   input  logic            dir,
   input  logic            start,
   output logic [2**N-1:0] y,
   output logic [N-1:0]    idx,
   output logic            busy,
   output logic            done
);

   localparam int W  = 2**N;
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [N-1:0]  LAST     = {N{1'b1}};
   localparam logic [PW-1:0] PMAX     = PW'(DIV - 1);
   localparam logic [W-1:0]  INACTIVE = {W{ACTIVE_LOW}};

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  idx_q, idx_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          dir_q, dir_d;
   logic          done_q, done_d;
   logic [W-1:0]  y_q, y_d;

   logic          tick;
   logic [PW-1:0] preNext;
   logic [N-1:0]  sweepLast;
   logic [N-1:0]  sweepStep;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         pre_q   <= '0;
         dir_q   <= 1'b0;
         done_q  <= 1'b0;
         y_q     <= INACTIVE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pre_q   <= pre_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
         y_q     <= y_d;
      end
   end

   // With e low everything holds; done is a pulse, so it is never held over.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pre_d     = pre_q;
      dir_d     = dir_q;
      done_d    = 1'b0;
      tick      = (pre_q == PMAX);
      preNext   = tick ? '0 : pre_q + PW'(1);
      sweepLast = dir_q ? '0 : LAST;
      sweepStep = dir_q ? idx_q - N'(1) : idx_q + N'(1);
      if (e) begin
         if (mode != 2'b10) begin
            state_d = IDLE;
         end
         unique case (mode)
            2'b00: begin
               idx_d = i;
               pre_d = '0;
            end
            2'b01: begin
               pre_d = preNext;
               if (tick) begin
                  idx_d = dir ? idx_q - N'(1) : idx_q + N'(1);
               end
            end
            2'b10: begin
               if (state_q == IDLE) begin
                  if (start) begin
                     state_d = SWEEP;
                     idx_d   = dir ? LAST : '0;
                     dir_d   = dir;
                     pre_d   = '0;
                  end
               end else begin
                  pre_d = preNext;
                  if (tick) begin
                     if (idx_q == sweepLast) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end else begin
                        idx_d = sweepStep;
                     end
                  end
               end
            end
            default: begin
               pre_d = '0;
            end
         endcase
      end
      y_d = e ? ((W'(1) << idx_d) ^ INACTIVE) : INACTIVE;
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign busy = (state_q == SWEEP);
   assign done = done_q;

endmodule

// File: tb/tb_dec_scan_n.sv
// Scoreboard bench for dec_scan_n: stimulus pushes hand-computed expectations,
// a monitor pops and compares them one step after each clock edge.
module tb_dec_scan_n;

   typedef struct {
      logic [3:0] y;
      logic [1:0] idx;
      logic       busy;
      logic       done;
      string      name;
   } expT;

   logic       clk = 1'b0;
   logic       rst, e, dir, start;
   logic [1:0] i, mode;
   logic [3:0] y;
   logic [1:0] idx;
   logic       busy, done;

   logic       rst1, e1, dir1, start1;
   logic [2:0] i1;
   logic [1:0] mode1;
   logic [7:0] y1;
   logic [2:0] idx1;
   logic       busy1, done1;

   expT sb[$];
   int  checks = 0;
   int  errors = 0;

   dec_scan_n #(.N(2), .DIV(4), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst(rst), .e(e), .i(i), .mode(mode), .dir(dir), .start(start),
      .y(y), .idx(idx), .busy(busy), .done(done)
   );

   dec_scan_n #(.N(3), .DIV(2), .ACTIVE_LOW(1'b1)) dutLow (
      .clk(clk), .rst(rst1), .e(e1), .i(i1), .mode(mode1), .dir(dir1), .start(start1),
      .y(y1), .idx(idx1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic applyStimulus(input logic eV, input logic [1:0] iV, input logic [1:0] modeV,
                                input logic dirV, input logic startV, input logic [3:0] expY,
                                input logic [1:0] expIdx, input logic expBusy, input logic expDone,
                                input string nm);
      expT x;
      @(negedge clk);
      e = eV; i = iV; mode = modeV; dir = dirV; start = startV;
      x.y = expY; x.idx = expIdx; x.busy = expBusy; x.done = expDone; x.name = nm;
      sb.push_back(x);
   endtask

   // Each pushed expectation describes the outputs just after the following edge.
   always @(posedge clk) begin : monitor
      expT x;
      #1;
      if (sb.size() != 0) begin
         x = sb.pop_front();
         checkOutput({x.name, ".y"},    {4'b0, y},    {4'b0, x.y});
         checkOutput({x.name, ".idx"},  {6'b0, idx},  {6'b0, x.idx});
         checkOutput({x.name, ".busy"}, {7'b0, busy}, {7'b0, x.busy});
         checkOutput({x.name, ".done"}, {7'b0, done}, {7'b0, x.done});
      end
   end

   initial begin
      int ex;
      rst = 1'b0; e = 1'b0; i = '0; mode = '0; dir = 1'b0; start = 1'b0;
      rst1 = 1'b0; e1 = 1'b0; i1 = '0; mode1 = '0; dir1 = 1'b0; start1 = 1'b0;
      #1;
      rst = 1'b1; rst1 = 1'b1;
      #1;
      checkOutput("reset.y",    {4'b0, y},    8'h00);
      checkOutput("reset.idx",  {6'b0, idx},  8'h00);
      checkOutput("reset.busy", {7'b0, busy}, 8'h00);
      checkOutput("reset.done", {7'b0, done}, 8'h00);
      checkOutput("resetLow.y", y1,           8'hFF);
      @(negedge clk);
      rst = 1'b0;

      applyStimulus(1, 2, 0, 0, 0, 4'b0100, 2, 0, 0, "direct_i2");
      applyStimulus(1, 0, 0, 0, 0, 4'b0001, 0, 0, 0, "direct_i0");
      applyStimulus(1, 1, 0, 0, 0, 4'b0010, 1, 0, 0, "direct_i1");
      applyStimulus(1, 2, 0, 0, 0, 4'b0100, 2, 0, 0, "direct_i2b");
      applyStimulus(1, 3, 0, 0, 0, 4'b1000, 3, 0, 0, "direct_i3");
      applyStimulus(0, 0, 0, 0, 0, 4'b0000, 3, 0, 0, "blank");
      applyStimulus(1, 0, 0, 0, 0, 4'b0001, 0, 0, 0, "pre_scan");

      // Index steps on every fourth enabled edge, wrapping back to 0 on the sixteenth.
      for (int s = 0; s < 18; s++) begin
         ex = ((s + 1) >> 2) & 3;
         applyStimulus(1, 0, 1, 0, 0, 4'(1 << ex), 2'(ex), 0, 0, "scan_up");
      end
      applyStimulus(1, 0, 1, 1, 0, 4'b0001, 0, 0, 0, "scan_dir_set");
      applyStimulus(1, 0, 1, 1, 0, 4'b1000, 3, 0, 0, "scan_down_tick");
      applyStimulus(1, 0, 1, 1, 0, 4'b1000, 3, 0, 0, "scan_down_hold");
      applyStimulus(1, 0, 3, 1, 0, 4'b1000, 3, 0, 0, "hold");

      applyStimulus(1, 0, 2, 1, 1, 4'b1000, 3, 1, 0, "sweep_launch");
      for (int t = 1; t < 16; t++) begin
         ex = 3 - (t >> 2);
         applyStimulus(1, 0, 2, (t >= 9 && t <= 11) ? 1'b0 : 1'b1, (t == 6) ? 1'b1 : 1'b0,
                       4'(1 << ex), 2'(ex), 1, 0, "sweep_down");
      end
      applyStimulus(1, 0, 2, 1, 0, 4'b0001, 0, 0, 1, "sweep_done");
      applyStimulus(1, 0, 2, 1, 1, 4'b1000, 3, 1, 0, "restart_on_done");
      applyStimulus(1, 0, 3, 1, 0, 4'b1000, 3, 0, 0, "abort_hold");

      applyStimulus(1, 0, 2, 0, 1, 4'b0001, 0, 1, 0, "launch_up");
      for (int t = 1; t < 4; t++) begin
         applyStimulus(1, 0, 2, 0, 0, 4'b0001, 0, 1, 0, "sweep_up");
      end
      applyStimulus(1, 0, 2, 0, 0, 4'b0010, 1, 1, 0, "sweep_up_step");
      for (int t = 0; t < 3; t++) begin
         applyStimulus(1, 0, 3, 0, 0, 4'b0010, 1, 0, 0, "abort_no_done");
      end

      applyStimulus(1, 0, 2, 0, 1, 4'b0001, 0, 1, 0, "relaunch");
      applyStimulus(1, 0, 2, 0, 0, 4'b0001, 0, 1, 0, "relaunch_run");
      applyStimulus(1, 0, 2, 0, 0, 4'b0001, 0, 1, 0, "relaunch_run");
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst.y",    {4'b0, y},    8'h00);
      checkOutput("async_rst.idx",  {6'b0, idx},  8'h00);
      checkOutput("async_rst.busy", {7'b0, busy}, 8'h00);
      checkOutput("async_rst.done", {7'b0, done}, 8'h00);
      @(negedge clk);
      checkOutput("rst_held.busy",  {7'b0, busy}, 8'h00);
      rst = 1'b0; e = 1'b0;
      applyStimulus(0, 1, 0, 0, 0, 4'b0000, 0, 0, 0, "post_reset_disabled");
      applyStimulus(1, 1, 0, 0, 0, 4'b0010, 1, 0, 0, "post_reset_direct");

      repeat (3) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain actual=%0d required=0 pending expectations", sb.size());
      end

      @(negedge clk);
      rst1 = 1'b0; e1 = 1'b1; i1 = 3'd5; mode1 = 2'b00;
      @(posedge clk);
      #1;
      checkOutput("low_direct.y",   y1,           8'hDF);
      checkOutput("low_direct.idx", {5'b0, idx1}, 8'h05);
      @(negedge clk);
      e1 = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("low_blank.y",    y1,           8'hFF);
      checkOutput("low_blank.idx",  {5'b0, idx1}, 8'h05);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
